// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: load/store types, FSM states and byte enables.
package mem_pkg;

  localparam logic [2:0] LOAD_LW  = 3'b000;
  localparam logic [2:0] LOAD_LB  = 3'b001;
  localparam logic [2:0] LOAD_LBU = 3'b010;
  localparam logic [2:0] LOAD_LH  = 3'b011;
  localparam logic [2:0] LOAD_LHU = 3'b100;

  localparam logic [1:0] STORE_SW = 2'b00;
  localparam logic [1:0] STORE_SB = 2'b01;
  localparam logic [1:0] STORE_SH = 2'b10;

  localparam logic [3:0] BE_ALL  = 4'b1111;
  localparam logic [3:0] BE_LO   = 4'b0011;
  localparam logic [3:0] BE_HI   = 4'b1100;
  localparam logic [3:0] BE_BYTE = 4'b0001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/mem_access_stage_align.sv
// Byte-lane steering: store replication and byte enables, load extract/extension,
// and alignment check for the current access type.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic        is_write,
  input  logic [2:0]  load_type,
  input  logic [1:0]  store_type,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [31:0] rshift;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign rshift   = rdata >> {addr_lo, 3'b000};
  assign byte_sel = rshift[7:0];
  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    be       = BE_ALL;
    wdata    = store_data;
    misalign = 1'b0;
    if (is_write) begin
      case (store_type)
        STORE_SB: begin
          be    = BE_BYTE << addr_lo;
          wdata = {4{store_data[7:0]}};
        end
        STORE_SH: begin
          be       = addr_lo[1] ? BE_HI : BE_LO;
          wdata    = {2{store_data[15:0]}};
          misalign = addr_lo[0];
        end
        default: misalign = |addr_lo;
      endcase
    end else begin
      case (load_type)
        LOAD_LB, LOAD_LBU: misalign = 1'b0;
        LOAD_LH, LOAD_LHU: misalign = addr_lo[0];
        default:           misalign = |addr_lo;
      endcase
    end
  end

  always_comb begin
    case (load_type)
      LOAD_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
      LOAD_LBU: load_data = {24'h000000, byte_sel};
      LOAD_LH:  load_data = {{16{half_sel[15]}}, half_sel};
      LOAD_LHU: load_data = {16'h0000, half_sel};
      default:  load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives the data-memory handshake, stalls while an access is
// outstanding and hands aligned/extended load data to MEM/WB.
//
// state  | meaning
// S_IDLE | no access outstanding; a new aligned access is requested this cycle
// S_WAIT | request issued, waiting for dmem_ready (timeout counter running)
// S_HOLD | data captured but MEM/WB stalled; replay latched data, no new request
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResult_in,
  input  logic [31:0] MemWriteData_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [2:0]  Load_in,
  input  logic [1:0]  Store_in,
  input  logic        WB_Stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic [31:0] MemReadData_o,
  output logic        MEM_Stall,
  output logic        misalign_o,
  output logic        buserr_o
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      held_data;

  logic        access;
  logic        mis_raw;
  logic        go;
  logic [31:0] load_data;
  logic [31:0] rd_now;

  mem_lane_align u_align (
    .addr_lo    (ALUResult_in[1:0]),
    .is_write   (MemWrite_in),
    .load_type  (Load_in),
    .store_type (Store_in),
    .store_data (MemWriteData_in),
    .rdata      (dmem_rdata),
    .be         (dmem_be),
    .wdata      (dmem_wdata),
    .load_data  (load_data),
    .misalign   (mis_raw)
  );

  assign access     = MemRead_in | MemWrite_in;
  assign go         = access & ~mis_raw;
  assign rd_now     = MemWrite_in ? 32'h0 : load_data;
  assign dmem_addr  = {ALUResult_in[31:2], 2'b00};
  assign dmem_we    = dmem_req & MemWrite_in;
  assign misalign_o = rst & access & mis_raw;

  // The cycle carrying buserr_o retires the faulted access, so no request is reissued then.
  always_comb begin
    dmem_req      = 1'b0;
    MEM_Stall     = 1'b0;
    MemReadData_o = 32'h0;
    case (state)
      S_IDLE: begin
        if (go && !buserr_o) begin
          dmem_req = 1'b1;
          if (dmem_ready) begin
            MEM_Stall     = WB_Stall;
            MemReadData_o = rd_now;
          end else begin
            MEM_Stall = 1'b1;
          end
        end
      end
      S_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          MEM_Stall     = WB_Stall;
          MemReadData_o = rd_now;
        end else begin
          MEM_Stall = 1'b1;
        end
      end
      S_HOLD: begin
        MEM_Stall     = WB_Stall;
        MemReadData_o = held_data;
      end
      default: ;
    endcase
    if (!rst) begin
      dmem_req      = 1'b0;
      MEM_Stall     = 1'b0;
      MemReadData_o = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      held_data <= 32'h0;
      buserr_o  <= 1'b0;
    end else begin
      buserr_o <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (go && !buserr_o) begin
            if (dmem_ready) begin
              if (WB_Stall) begin
                held_data <= rd_now;
                state     <= S_HOLD;
              end
            end else if (TO_EN && TIMEOUT == 1) begin
              buserr_o <= 1'b1;
            end else begin
              cnt   <= CNT_W'(1);
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (dmem_ready) begin
            cnt <= '0;
            if (WB_Stall) begin
              held_data <= rd_now;
              state     <= S_HOLD;
            end else begin
              state <= S_IDLE;
            end
          end else if (TO_EN && cnt == TO_LAST) begin
            buserr_o <= 1'b1;
            cnt      <= '0;
            state    <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HOLD: begin
          cnt <= '0;
          if (!WB_Stall) state <= S_IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
